// File: rtl/gate_tt_checker_pkg.sv
// Shared state encoding and two-input truth-table constants for the gate checker.
package tc_check_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } chk_state_t;

  // Bit k is the expected output for input vector k.
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/gate_tt_checker_sat_counter.sv
// Saturating up-counter used as the mismatch tally; clr restarts it for a new sweep.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps all input vectors of a single-output gate, waits SETTLE cycles per vector,
// and compares the sampled output against TRUTH_TABLE to produce a registered verdict.
module gate_tt_checker #(
  parameter int                        N_IN        = 2,
  parameter logic [(1 << N_IN) - 1:0]  TRUTH_TABLE = 4'b0110,
  parameter int                        SETTLE      = 1,
  parameter int                        CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_fail_valid,
  output logic [N_IN-1:0]  first_fail_vec
);
  import tc_check_pkg::*;

  localparam logic [3:0]  SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
  localparam logic [N_IN:0] LAST_VEC  = {1'b0, {N_IN{1'b1}}};

  chk_state_t    state;
  chk_state_t    state_nxt;
  logic [N_IN:0] vec;
  logic [3:0]    wait_cnt;
  logic          launch;
  logic          sample;
  logic          last_vec;
  logic          mismatch;

  assign launch   = start && ((state == IDLE) || (state == DONE));
  assign sample   = (state == SAMPLE);
  assign last_vec = (vec == LAST_VEC);
  assign mismatch = sample && (dut_out != TRUTH_TABLE[vec[N_IN-1:0]]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (SETTLE == 0) ? SAMPLE : tc_check_pkg::SETTLE;
        end
      end
      tc_check_pkg::SETTLE: begin
        if (wait_cnt == SETTLE_LAST) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_vec) begin
          state_nxt = DONE;
        end else if (SETTLE != 0) begin
          state_nxt = tc_check_pkg::SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The extra counter bit keeps the end-of-sweep test independent of wrap-around.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec              <= '0;
      wait_cnt         <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      if (launch) begin
        vec              <= '0;
        first_fail_valid <= 1'b0;
        first_fail_vec   <= '0;
      end else begin
        if (sample && !last_vec) begin
          vec <= vec + (N_IN + 1)'(1);
        end
        if (mismatch && !first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_vec   <= vec[N_IN-1:0];
        end
      end
      if (state == tc_check_pkg::SETTLE) begin
        wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (launch),
    .inc (mismatch),
    .cnt (err_cnt)
  );

  assign dut_in = vec[N_IN-1:0];
  assign busy   = (state == tc_check_pkg::SETTLE) || (state == SAMPLE);
  assign done   = (state == DONE);
  assign pass   = done && (err_cnt == '0);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench: three checker instances with model gates on dut_out and hand-derived expectations.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic st0 = 1'b0;
  logic st1 = 1'b0;
  logic st2 = 1'b0;
  int   mode = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [1:0] in0, ffvec0;
  logic [7:0] err0;
  logic       out0, busy0, done0, pass0, ffv0;

  logic [1:0] in1, ffvec1;
  logic [7:0] err1;
  logic       out1, busy1, done1, pass1, ffv1;

  logic [2:0] in2, ffvec2;
  logic [1:0] err2;
  logic       out2, busy2, done2, pass2, ffv2;

  always #5 clk = ~clk;

  // Model gates: 0 ideal XOR, 1 stuck-at-0, 2 inverted XOR.
  always_comb begin
    out0 = ^in0;
    if (mode == 1) out0 = 1'b0;
    else if (mode == 2) out0 = ~(^in0);
  end
  assign out1 = ~(^in1);
  assign out2 = ~(^in2);

  gate_tt_checker u0 (
    .clk(clk), .rst(rst), .start(st0), .dut_in(in0), .dut_out(out0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
  );

  gate_tt_checker #(.N_IN(2), .TRUTH_TABLE(4'b0110), .SETTLE(0), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .start(st1), .dut_in(in1), .dut_out(out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .first_fail_valid(ffv1), .first_fail_vec(ffvec1)
  );

  gate_tt_checker #(.N_IN(3), .TRUTH_TABLE(8'h96), .SETTLE(1), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .start(st2), .dut_in(in2), .dut_out(out2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Full default-latency sweep on u0; edge 0 samples start, done expected after edge 8.
  task automatic sweep0(input string tag, input bit repulse);
    @(negedge clk); st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
    check({tag, "_busy_e0"}, 32'(busy0), 32'd1);
    check({tag, "_done_e0"}, 32'(done0), 32'd0);
    check({tag, "_err_e0"},  32'(err0),  32'd0);
    check({tag, "_vec0"},    32'(in0),   32'd0);
    repeat (2) @(negedge clk);
    check({tag, "_vec1"}, 32'(in0), 32'd1);
    if (repulse) st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
    @(negedge clk);
    check({tag, "_vec2"}, 32'(in0), 32'd2);
    repeat (2) @(negedge clk);
    check({tag, "_vec3"}, 32'(in0), 32'd3);
    @(negedge clk);
    check({tag, "_done_e7"}, 32'(done0), 32'd0);
    check({tag, "_busy_e7"}, 32'(busy0), 32'd1);
    @(negedge clk);
    check({tag, "_done_e8"}, 32'(done0), 32'd1);
    check({tag, "_busy_e8"}, 32'(busy0), 32'd0);
    check({tag, "_vec_hold"}, 32'(in0), 32'd3);
  endtask

  initial begin
    // Reset held together with start: reset must win.
    st0 = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_done",  32'(done0),  32'd0);
    check("rst_pass",  32'(pass0),  32'd0);
    check("rst_dutin", 32'(in0),    32'd0);
    check("rst_err",   32'(err0),   32'd0);
    check("rst_ffv",   32'(ffv0),   32'd0);
    check("rst_ffvec", 32'(ffvec0), 32'd0);
    check("rst_busy1", 32'(busy1),  32'd0);
    check("rst_busy2", 32'(busy2),  32'd0);
    st0 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy0), 32'd0);

    mode = 0;
    sweep0("xor", 1'b0);
    check("xor_pass", 32'(pass0), 32'd1);
    check("xor_err",  32'(err0),  32'd0);
    check("xor_ffv",  32'(ffv0),  32'd0);

    // Starting from DONE also exercises the restart path.
    mode = 1;
    sweep0("sa0", 1'b0);
    check("sa0_err",   32'(err0),   32'd2);
    check("sa0_ffv",   32'(ffv0),   32'd1);
    check("sa0_ffvec", 32'(ffvec0), 32'd1);
    check("sa0_pass",  32'(pass0),  32'd0);

    mode = 0;
    sweep0("repulse", 1'b1);
    check("repulse_pass", 32'(pass0), 32'd1);
    check("repulse_ffv",  32'(ffv0),  32'd0);

    // Reset sampled at edge 4 of a failing sweep.
    mode = 2;
    @(negedge clk); st0 = 1'b1;
    @(negedge clk); st0 = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_err", 32'(err0), 32'd1);
    check("pre_rst_ffv", 32'(ffv0), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mid_rst_busy",  32'(busy0), 32'd0);
    check("mid_rst_done",  32'(done0), 32'd0);
    check("mid_rst_err",   32'(err0),  32'd0);
    check("mid_rst_dutin", 32'(in0),   32'd0);
    check("mid_rst_ffv",   32'(ffv0),  32'd0);
    mode = 0;
    sweep0("post_rst", 1'b0);
    check("post_rst_pass", 32'(pass0), 32'd1);

    // XNOR gate against XOR table, no settle time.
    @(negedge clk); st1 = 1'b1;
    @(negedge clk); st1 = 1'b0;
    check("s0_busy_e0", 32'(busy1), 32'd1);
    repeat (3) @(negedge clk);
    check("s0_done_e3",  32'(done1), 32'd0);
    check("s0_dutin_e3", 32'(in1),   32'd3);
    @(negedge clk);
    check("s0_done_e4", 32'(done1),  32'd1);
    check("s0_err",     32'(err1),   32'd4);
    check("s0_ffv",     32'(ffv1),   32'd1);
    check("s0_ffvec",   32'(ffvec1), 32'd0);
    check("s0_pass",    32'(pass1),  32'd0);

    // Three-input parity, inverted output, 2-bit counter saturates.
    @(negedge clk); st2 = 1'b1;
    @(negedge clk); st2 = 1'b0;
    repeat (15) @(negedge clk);
    check("n3_done_e15", 32'(done2), 32'd0);
    @(negedge clk);
    check("n3_done_e16", 32'(done2),  32'd1);
    check("n3_err_sat",  32'(err2),   32'd3);
    check("n3_ffv",      32'(ffv2),   32'd1);
    check("n3_ffvec",    32'(ffvec2), 32'd0);
    check("n3_pass",     32'(pass2),  32'd0);
    check("n3_dutin",    32'(in2),    32'd7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
